// File: rtl/arb_burst_frontend.sv
`default_nettype none
// ============================================================================
// Module      : arb_burst_frontend
// Description : Upstream stage of a 4-way round-robin arbiter. Buffers write
//               traffic from 4 clients in per-client FWFT FIFOs, raises req
//               per client, and streams the granted client's words onto one
//               shared bus in bursts of at most BURST_MAX beats. After each
//               burst the client drops req for one cycle so the arbiter can
//               rotate to another client.
// Ports       : clk, rst            - clock, async active-high reset
//               s_valid/s_data/s_ready - 4 client write ports (bit n = client n)
//               req/gnt             - to / from the (registered) arbiter
//               m_valid/m_data/m_id/m_last/m_ready - shared output bus
//               gnt_err             - sticky protocol-error flag
// Revision    : 1.0 - initial release
// ============================================================================
module arb_burst_frontend #(
    parameter int DW        = 8,
    parameter int DEPTH     = 4,
    parameter int BURST_MAX = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [3:0]      s_valid,
    input  logic [4*DW-1:0] s_data,
    output logic [3:0]      s_ready,
    output logic [3:0]      req,
    input  logic [3:0]      gnt,
    output logic            m_valid,
    output logic [DW-1:0]   m_data,
    output logic [1:0]      m_id,
    output logic            m_last,
    input  logic            m_ready,
    output logic            gnt_err
);

    localparam int         AW        = $clog2(DEPTH);
    localparam int         CW        = AW + 1;
    localparam logic [7:0] LAST_BEAT = 8'(BURST_MAX - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_XFER = 2'd2,
        ST_REL  = 2'd3
    } state_t;

    // Per-client status gathered into flat vectors for the shared bus logic
    logic [4*DW-1:0] head_all;
    logic [3:0]      in_xfer;
    logic [3:0]      is_idle;
    logic [3:0]      cnt_one;
    logic [3:0]      beat_last;
    logic [3:0]      pop;
    logic [1:0]      sel;

    logic            gnt_err_q;
    logic            gnt_err_d;
    logic            multi_gnt;
    logic            multi_xfer;
    logic            gnt_idle;

    // ------------------------------------------------------------------------
    // Per-client FIFO and request FSM
    // ------------------------------------------------------------------------
    for (genvar n = 0; n < 4; n++) begin : g_client
        state_t          state_q;
        state_t          state_d;
        logic [CW-1:0]   count_q;
        logic [CW-1:0]   count_d;
        logic [AW-1:0]   wr_ptr_q;
        logic [AW-1:0]   wr_ptr_d;
        logic [AW-1:0]   rd_ptr_q;
        logic [AW-1:0]   rd_ptr_d;
        logic [7:0]      beat_q;
        logic [7:0]      beat_d;
        logic [DW-1:0]   mem_q [DEPTH];
        logic            push;

        assign s_ready[n] = (count_q < CW'(DEPTH));
        assign push       = s_valid[n] & s_ready[n];

        // First-word-fall-through: the head word is always visible
        assign head_all[n*DW +: DW] = mem_q[rd_ptr_q];

        assign in_xfer[n]   = (state_q == ST_XFER);
        assign is_idle[n]   = (state_q == ST_IDLE);
        assign req[n]       = (state_q == ST_REQ) | (state_q == ST_XFER);
        assign cnt_one[n]   = (count_q == CW'(1));
        assign beat_last[n] = (beat_q == LAST_BEAT);

        always_comb begin
            count_d  = count_q;
            wr_ptr_d = wr_ptr_q;
            rd_ptr_d = rd_ptr_q;
            if (push) begin
                wr_ptr_d = wr_ptr_q + 1'b1;
            end
            if (pop[n]) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            case ({push, pop[n]})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end

        always_comb begin
            state_d = state_q;
            beat_d  = beat_q;
            case (state_q)
                ST_IDLE: begin
                    if (count_q != '0) begin
                        state_d = ST_REQ;
                    end
                end
                ST_REQ: begin
                    if (gnt[n]) begin
                        state_d = ST_XFER;
                        beat_d  = '0;
                    end
                end
                ST_XFER: begin
                    if (pop[n]) begin
                        beat_d = beat_q + 8'd1;
                        if (m_last) begin
                            state_d = ST_REL;
                        end
                    end
                end
                ST_REL: begin
                    // One cycle with req low; gnt is still high here because
                    // the arbiter's grant lags req by a cycle, so it is ignored.
                    state_d = (count_q != '0) ? ST_REQ : ST_IDLE;
                end
                default: state_d = ST_IDLE;
            endcase
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                state_q  <= ST_IDLE;
                count_q  <= '0;
                wr_ptr_q <= '0;
                rd_ptr_q <= '0;
                beat_q   <= '0;
            end else begin
                state_q  <= state_d;
                count_q  <= count_d;
                wr_ptr_q <= wr_ptr_d;
                rd_ptr_q <= rd_ptr_d;
                beat_q   <= beat_d;
            end
        end

        // Storage needs no reset: occupancy is tracked by the pointers
        always_ff @(posedge clk) begin
            if (push) begin
                mem_q[wr_ptr_q] <= s_data[n*DW +: DW];
            end
        end
    end

    // ------------------------------------------------------------------------
    // Shared bus: lowest-index client in XFER owns the bus. Normally only one
    // client can be in XFER; the priority only matters after a protocol error.
    // ------------------------------------------------------------------------
    always_comb begin
        sel = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (in_xfer[i]) begin
                sel = 2'(i);
            end
        end
    end

    assign m_valid = |in_xfer;
    assign m_id    = sel;
    assign m_data  = head_all[int'(sel)*DW +: DW];
    // A push in the same cycle is not yet in count, so it cannot extend the burst
    assign m_last  = m_valid & (beat_last[sel] | cnt_one[sel]);
    assign pop     = (m_valid && m_ready) ? (4'b0001 << sel) : 4'b0000;

    // ------------------------------------------------------------------------
    // Sticky protocol-error detection
    // ------------------------------------------------------------------------
    always_comb begin
        multi_gnt  = (gnt & (gnt - 4'd1)) != 4'd0;
        multi_xfer = (in_xfer & (in_xfer - 4'd1)) != 4'd0;
        gnt_idle   = (gnt & is_idle) != 4'd0;
        gnt_err_d  = gnt_err_q | multi_gnt | multi_xfer | gnt_idle;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            gnt_err_q <= 1'b0;
        end else begin
            gnt_err_q <= gnt_err_d;
        end
    end

    assign gnt_err = gnt_err_q;

endmodule
`default_nettype wire

// File: tb/tb_arb_burst_frontend.sv
`default_nettype none
// ============================================================================
// Module      : tb_arb_burst_frontend
// Description : Self-checking bench for arb_burst_frontend. Per-client source
//               queues feed the write ports, a registered round-robin arbiter
//               model answers req, and a per-client scoreboard checks every
//               beat's data and m_last against an independent burst model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_arb_burst_frontend;

    localparam int DW        = 8;
    localparam int DEPTH     = 4;
    localparam int BURST_MAX = 4;

    logic            clk = 1'b0;
    logic            rst;
    logic [3:0]      s_valid;
    logic [4*DW-1:0] s_data;
    logic [3:0]      s_ready;
    logic [3:0]      req;
    logic [3:0]      gnt;
    logic            m_valid;
    logic [DW-1:0]   m_data;
    logic [1:0]      m_id;
    logic            m_last;
    logic            m_ready;
    logic            gnt_err;

    int n_checks = 0;
    int n_errors = 0;

    logic [DW-1:0] src_q [4][$];
    logic [DW-1:0] exp_q [4][$];
    int            bc    [4];
    int            beats [4];
    int            lasts [4];
    int            burst_log [$];

    logic [3:0] arb_gnt;
    int         arb_last;
    logic       arb_force;
    logic [3:0] force_val;

    logic [DW-1:0] cap_data;
    logic [1:0]    cap_id;

    arb_burst_frontend #(
        .DW        (DW),
        .DEPTH     (DEPTH),
        .BURST_MAX (BURST_MAX)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .s_valid (s_valid),
        .s_data  (s_data),
        .s_ready (s_ready),
        .req     (req),
        .gnt     (gnt),
        .m_valid (m_valid),
        .m_data  (m_data),
        .m_id    (m_id),
        .m_last  (m_last),
        .m_ready (m_ready),
        .gnt_err (gnt_err)
    );

    always #5 clk = ~clk;

    assign gnt = arb_force ? force_val : arb_gnt;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Registered round-robin arbiter: holds the grant while the owner keeps
    // req high, otherwise grants the next requester after the last owner.
    always @(posedge clk or posedge rst) begin : arb
        logic [3:0] ng;
        int         nl;
        if (rst) begin
            arb_gnt  <= 4'd0;
            arb_last <= 3;
        end else if ((arb_gnt & req) != 4'd0) begin
            arb_gnt <= arb_gnt;
        end else begin
            ng = 4'd0;
            nl = arb_last;
            for (int i = 1; i <= 4; i++) begin
                int idx;
                idx = (arb_last + i) % 4;
                if (ng == 4'd0 && req[idx]) begin
                    ng = 4'b0001 << idx;
                    nl = idx;
                end
            end
            arb_gnt  <= ng;
            arb_last <= nl;
        end
    end

    // Source driver: present the head of each client's source queue
    always @(posedge clk) begin
        #1;
        for (int n = 0; n < 4; n++) begin
            if (!rst && src_q[n].size() > 0) begin
                s_valid[n]          = 1'b1;
                s_data[n*DW +: DW]  = src_q[n][0];
            end else begin
                s_valid[n] = 1'b0;
            end
        end
    end

    // Monitor: beats are checked before this cycle's pushes are recorded so a
    // same-cycle push never counts toward the burst end.
    always @(negedge clk) begin : mon
        int            id;
        logic [DW-1:0] ed;
        logic          el;
        if (!rst) begin
            if (m_valid && m_ready) begin
                id = int'(m_id);
                check_eq("beat_pending", 32'(exp_q[id].size() > 0), 32'd1);
                if (exp_q[id].size() > 0) begin
                    ed = exp_q[id].pop_front();
                    el = (bc[id] == BURST_MAX - 1) || (exp_q[id].size() == 0);
                    check_eq("beat_data", 32'(m_data), 32'(ed));
                    check_eq("beat_last", 32'(m_last), 32'(el));
                    beats[id]++;
                    if (el) begin
                        lasts[id]++;
                        burst_log.push_back(id);
                        bc[id] = 0;
                    end else begin
                        bc[id]++;
                    end
                end
            end
            for (int n = 0; n < 4; n++) begin
                if (s_valid[n] && s_ready[n]) begin
                    exp_q[n].push_back(s_data[n*DW +: DW]);
                    if (src_q[n].size() > 0) begin
                        void'(src_q[n].pop_front());
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_stats();
        for (int i = 0; i < 4; i++) begin
            beats[i] = 0;
            lasts[i] = 0;
        end
        burst_log.delete();
    endtask

    task automatic flush_model();
        for (int i = 0; i < 4; i++) begin
            src_q[i].delete();
            exp_q[i].delete();
            bc[i] = 0;
        end
        clear_stats();
    endtask

    function automatic bit all_empty();
        for (int i = 0; i < 4; i++) begin
            if (src_q[i].size() != 0 || exp_q[i].size() != 0) return 1'b0;
        end
        return 1'b1;
    endfunction

    task automatic wait_drain(input string tag, input int max_cyc);
        bit done;
        done = 1'b0;
        for (int k = 0; k < max_cyc && !done; k++) begin
            @(negedge clk);
            if (all_empty() && !m_valid && req == 4'd0) done = 1'b1;
        end
        check_eq(tag, 32'(done), 32'd1);
    endtask

    task automatic wait_mvalid(input string tag, input int max_cyc);
        bit found;
        found = 1'b0;
        for (int k = 0; k < max_cyc && !found; k++) begin
            @(negedge clk);
            if (m_valid) found = 1'b1;
        end
        check_eq(tag, 32'(found), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        rst       = 1'b1;
        s_valid   = 4'd0;
        s_data    = '0;
        m_ready   = 1'b1;
        arb_force = 1'b0;
        force_val = 4'd0;
        flush_model();

        // ---------------- reset state ----------------
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_req",     32'(req),     32'h0);
        check_eq("rst_m_valid", 32'(m_valid), 32'h0);
        check_eq("rst_m_last",  32'(m_last),  32'h0);
        check_eq("rst_m_id",    32'(m_id),    32'h0);
        check_eq("rst_s_ready", 32'(s_ready), 32'hF);
        check_eq("rst_gnt_err", 32'(gnt_err), 32'h0);
        @(negedge clk);
        rst = 1'b0;

        // ---------------- client 0: two words, latency and release ----------------
        src_q[0].push_back(8'hA1);
        src_q[0].push_back(8'hB2);
        @(negedge clk);                                   // A presented, pushed next edge
        @(negedge clk);
        check_eq("t1_req_early", 32'(req), 32'h0);
        @(negedge clk);
        check_eq("t1_req", 32'(req), 32'h1);
        check_eq("t1_mvalid_req", 32'(m_valid), 32'h0);
        @(negedge clk);
        check_eq("t1_mvalid_gnt", 32'(m_valid), 32'h0);
        @(negedge clk);
        check_eq("t1_mvalid", 32'(m_valid), 32'h1);
        check_eq("t1_mid", 32'(m_id), 32'h0);
        @(negedge clk);
        check_eq("t1_last", 32'(m_last), 32'h1);
        @(negedge clk);
        check_eq("t1_rel_req", 32'(req), 32'h0);
        check_eq("t1_rel_mvalid", 32'(m_valid), 32'h0);
        @(negedge clk);
        check_eq("t1_idle_req", 32'(req), 32'h0);
        check_eq("t1_no_err", 32'(gnt_err), 32'h0);
        check_eq("t1_beats", 32'(beats[0]), 32'd2);

        // ---------------- clients 1 and 2: six words each ----------------
        clear_stats();
        for (int i = 0; i < 6; i++) begin
            src_q[1].push_back(8'(8'h10 + i));
            src_q[2].push_back(8'(8'h20 + i));
        end
        wait_drain("t2_drain", 300);
        check_eq("t2_beats1", 32'(beats[1]), 32'd6);
        check_eq("t2_beats2", 32'(beats[2]), 32'd6);
        check_eq("t2_lasts1", 32'(lasts[1]), 32'd2);
        check_eq("t2_lasts2", 32'(lasts[2]), 32'd2);
        check_eq("t2_nbursts", 32'(burst_log.size()), 32'd4);
        if (burst_log.size() == 4) begin
            check_eq("t2_order0", 32'(burst_log[0]), 32'd1);
            check_eq("t2_order1", 32'(burst_log[1]), 32'd2);
            check_eq("t2_order2", 32'(burst_log[2]), 32'd1);
            check_eq("t2_order3", 32'(burst_log[3]), 32'd2);
        end
        check_eq("t2_no_err", 32'(gnt_err), 32'h0);

        // ---------------- back-pressure stall mid-burst ----------------
        clear_stats();
        for (int i = 0; i < 4; i++) src_q[0].push_back(8'(8'h30 + i));
        wait_mvalid("t3_start", 50);
        @(posedge clk);                                   // beat 1 accepted here
        #1;
        m_ready = 1'b0;
        @(negedge clk);
        cap_data = m_data;
        cap_id   = m_id;
        if (exp_q[0].size() > 0) check_eq("t3_head", 32'(m_data), 32'(exp_q[0][0]));
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check_eq("t3_stall_valid", 32'(m_valid), 32'h1);
            check_eq("t3_stall_data",  32'(m_data),  32'(cap_data));
            check_eq("t3_stall_id",    32'(m_id),    32'(cap_id));
            check_eq("t3_stall_last",  32'(m_last),  32'h0);
        end
        tick();
        m_ready = 1'b1;
        wait_drain("t3_drain", 100);
        check_eq("t3_beats", 32'(beats[0]), 32'd4);
        check_eq("t3_lasts", 32'(lasts[0]), 32'd1);

        // ---------------- client 3 full, then pop+push at DEPTH-1 ----------------
        clear_stats();
        tick();
        m_ready = 1'b0;
        for (int i = 0; i < 5; i++) src_q[3].push_back(8'(8'h40 + i));
        repeat (8) @(negedge clk);
        check_eq("t4_full_sready", 32'(s_ready[3]), 32'h0);
        check_eq("t4_full_held",   32'(src_q[3].size()), 32'd1);
        check_eq("t4_mid",         32'(m_id), 32'd3);
        tick();
        m_ready = 1'b1;
        tick();                                           // pop only
        tick();                                           // pop + push
        m_ready = 1'b0;
        @(negedge clk);
        check_eq("t4_popush_sready", 32'(s_ready[3]), 32'h1);
        src_q[3].push_back(8'h4F);
        repeat (3) @(negedge clk);
        check_eq("t4_popush_count", 32'(s_ready[3]), 32'h0);
        tick();
        m_ready = 1'b1;
        wait_drain("t4_drain", 100);
        check_eq("t4_beats", 32'(beats[3]), 32'd6);
        check_eq("t4_lasts", 32'(lasts[3]), 32'd2);

        // ---------------- two grants at once -> sticky error ----------------
        tick();
        arb_force = 1'b1;
        force_val = 4'b0011;
        tick();
        arb_force = 1'b0;
        @(negedge clk);
        check_eq("t5_err_multi", 32'(gnt_err), 32'h1);
        repeat (5) @(negedge clk);
        check_eq("t5_err_sticky", 32'(gnt_err), 32'h1);

        // ---------------- reset during beat 2 of 4 ----------------
        clear_stats();
        for (int i = 0; i < 4; i++) src_q[0].push_back(8'(8'h50 + i));
        wait_mvalid("t6_start", 50);
        @(posedge clk);
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        check_eq("t6_req",     32'(req),     32'h0);
        check_eq("t6_m_valid", 32'(m_valid), 32'h0);
        check_eq("t6_m_last",  32'(m_last),  32'h0);
        check_eq("t6_s_ready", 32'(s_ready), 32'hF);
        check_eq("t6_gnt_err", 32'(gnt_err), 32'h0);
        flush_model();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (6) @(negedge clk);
        check_eq("t6_post_req",    32'(req),     32'h0);
        check_eq("t6_post_mvalid", 32'(m_valid), 32'h0);

        // ---------------- grant to an idle client -> sticky error ----------------
        tick();
        arb_force = 1'b1;
        force_val = 4'b0100;
        tick();
        arb_force = 1'b0;
        @(negedge clk);
        check_eq("t7_err_idle", 32'(gnt_err), 32'h1);
        repeat (3) @(negedge clk);
        check_eq("t7_err_sticky", 32'(gnt_err), 32'h1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
